fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Parametrised instruction prefetch queue that replaces the fixed single-register fetch path between program memory and the ID stage. It drives the program-memory address, captures returning instructions into a DEPTH-entry FIFO of {pc, inst} pairs, and presents them to ID under a stall/valid handshake. Jumps redirect fetch and squash all queued and in-flight instructions. Each core in the cluster instantiates one fetch_buffer.

## Interface
- INST_W, 32, instruction width
- ADDR_W, 16, program-memory word address width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  global core enable
- progmem_addr  out  ADDR_W  fetch address; memory returns data one cycle later
- progmem_data  in  INST_W  read data for the address presented the previous cycle
- jump  in  1  redirect request from EX
- jump_addr  in  ADDR_W  redirect target
- stall  in  1  ID cannot accept this cycle
- out_valid  out  1  head entry valid
- out_inst  out  INST_W  head instruction; 0 when out_valid=0
- out_pc  out  ADDR_W  head pc; 0 when out_valid=0
- count  out  clog2(DEPTH+1)  occupied entries

## Operation
- State: pc register, FIFO (rd/wr pointers, count), inflight bit (request issued last cycle, response due now).
- Issue condition: en && (jump || count + inflight < DEPTH). Pop in the same cycle does not grant credit.
- progmem_addr = jump ? jump_addr : pc (combinational). On issue: pc ← issued address + 1 (wraps modulo 2^ADDR_W); inflight ← 1, else inflight ← 0.
- Capture: if inflight && !jump, write {issued pc, progmem_data} at FIFO tail. Capture occurs even when en=0.
- Pop: en && out_valid && !stall && !jump.
- jump (with en=1): FIFO cleared (count ← 0, pointers reset), current in-flight response discarded, pop suppressed, jump_addr issued the same cycle. jump with en=0 is ignored.
- en=0: no issue, no pop, pc held; a pending response is still captured (credit guarantees space), then inflight ← 0.
- Simultaneous capture and pop: count unchanged. Overflow is impossible by credit rule. Pop on empty is impossible (out_valid=0).
- Reset: pc=RESET_PC, count=0, inflight=0, pointers 0. Outputs: out_valid=0, out_inst=0, out_pc=0, count=0, progmem_addr=RESET_PC. Reset mid-operation drops all entries immediately.

## Timing
- After rst_n deassert, first edge T0 issues RESET_PC; captured at T1; out_valid=1 from T2 (registered FIFO output).
- Steady state without stall: one instruction per cycle.
- Jump at cycle T: target issued at T, captured at T+1, visible at T+2 (T+1 with bypass, see Configuration). No pre-jump instruction is visible at or after T+1.
- Stall-to-full: the FIFO fills within DEPTH cycles of stall assertion; issue stops when count + inflight = DEPTH.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a response is captured this cycle, it is also driven combinationally on out_inst/out_pc with out_valid=1. If it is popped, it is not written into the FIFO. Jump-to-visible latency drops to 1 cycle, and the first instruction after reset is visible at T1.
- Undefined: outputs come only from FIFO state; latencies are as in Timing.

## Test plan
- Reset stream, DEPTH=4, mem[i]=0x1000+i: out_valid rises at T2 with pc 0/inst 0x1000, then pc 1,2,3… every cycle; count ≤1.
- Stall held 8 cycles mid-stream: count saturates at 4, progmem_addr stops advancing. After release, pcs continue consecutively with no gap or duplicate.
- jump to 0x40 while the FIFO holds 3 entries and one is in flight: count=0 next cycle, next visible pc=0x40 at T+2, then 0x41; no stale pc appears.
- en low for 3 cycles with a request in flight: the response is captured once, no new address is issued, and order is intact after en returns. A jump asserted during en=0 has no effect.
- pc wrap, ADDR_W=4, RESET_PC=0xE: out pcs 0xE, 0xF, 0x0, 0x1.
- rst_n asserted asynchronously mid-stream with the FIFO full: out_valid=0 and count=0 immediately. Refetch restarts at RESET_PC. With FETCH_BYPASS_EN, the first instruction is visible at T1 and a jump target at T+1.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Port bundle for fetch_buffer: program-memory fetch side, redirect/stall controls and ID delivery.
interface fetch_buffer_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              en;
  logic [ADDR_W-1:0] progmem_addr;
  logic [INST_W-1:0] progmem_data;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              stall;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    input  en, progmem_data, jump, jump_addr, stall,
    output progmem_addr, out_valid, out_inst, out_pc, count
  );

  modport slave (
    output en, progmem_data, jump, jump_addr, stall,
    input  progmem_addr, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: issues program-memory reads and buffers {pc, inst} pairs for ID.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is presented to ID the same cycle.
module fetch_buffer #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  fetch_buffer_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  logic              jump_eff;
  logic              issue;
  logic              capture;
  logic              fifo_empty;
  logic              head_valid;
  logic              pop;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [ADDR_W-1:0] fetch_addr;
  logic [OCC_W-1:0]  occupancy;
  entry_t            cap_entry;
  entry_t            head;

  // Issue only while queued plus in-flight entries leave room; a redirect always issues.
  always_comb begin
    jump_eff   = bus.en & bus.jump;
    fetch_addr = jump_eff ? bus.jump_addr : pc_q;
    occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q);
    issue      = bus.en & (jump_eff | (occupancy < OCC_W'(DEPTH)));
    capture    = inflight_q & ~jump_eff;
    cap_entry  = '{pc: issued_pc_q, inst: bus.progmem_data};
    fifo_empty = (count_q == '0);
  end

  always_comb begin
`ifdef FETCH_BYPASS_EN
    head_valid = ~fifo_empty | capture;
    head       = fifo_empty ? cap_entry : mem_q[rd_ptr_q];
    pop        = bus.en & head_valid & ~bus.stall & ~jump_eff;
    fifo_rd    = pop & ~fifo_empty;
    // A bypassed response consumed this cycle never occupies a slot.
    fifo_wr    = capture & ~(pop & fifo_empty);
`else
    head_valid = ~fifo_empty;
    head       = mem_q[rd_ptr_q];
    pop        = bus.en & head_valid & ~bus.stall & ~jump_eff;
    fifo_rd    = pop;
    fifo_wr    = capture;
`endif
  end

  always_comb begin
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = issue;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    if (issue) begin
      pc_d        = fetch_addr + ADDR_W'(1);
      issued_pc_d = fetch_addr;
    end
    if (jump_eff) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_wr) begin
        mem_d[wr_ptr_q] = cap_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (fifo_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= RESET_PC;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_q       <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.progmem_addr = fetch_addr;
  assign bus.out_valid    = head_valid;
  assign bus.out_inst     = head_valid ? head.inst : '0;
  assign bus.out_pc       = head_valid ? head.pc : '0;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_buffer;
  localparam int unsigned       INST_W   = 32;
  localparam int unsigned       ADDR_W   = 16;
  localparam int unsigned       DEPTH    = 4;
  localparam int                MAXQ     = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;

  fetch_buffer_if #(.INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_buffer #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  // Program memory: one-cycle read latency.
  always @(posedge clk) bus.progmem_data <= mem_word(bus.progmem_addr);

  ent_t        q[$];
  logic [15:0] m_pc;
  logic        m_if;
  logic [15:0] m_ifpc;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_if   = 1'b0;
    m_ifpc = RESET_PC;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model over the edge.
  task automatic step(input logic i_en, input logic i_jump, input logic [15:0] i_ja,
                      input logic i_stall);
    logic        jeff, cap, hv, iss, pp;
    logic [15:0] eaddr;
    ent_t        head;
    bus.en        = i_en;
    bus.jump      = i_jump;
    bus.jump_addr = i_ja;
    bus.stall     = i_stall;
    #1;
    jeff  = i_en && i_jump;
    cap   = m_if && !jeff;
    eaddr = jeff ? i_ja : m_pc;
    hv    = (q.size() != 0) || (BYP && cap);
    head  = (q.size() != 0) ? q[0] : '{pc: m_ifpc, inst: mem_word(m_ifpc)};
    chk("out_valid", 32'(bus.out_valid), 32'(hv));
    chk("out_pc", 32'(bus.out_pc), hv ? 32'(head.pc) : 32'h0);
    chk("out_inst", bus.out_inst, hv ? head.inst : 32'h0);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("progmem_addr", 32'(bus.progmem_addr), 32'(eaddr));
    iss = i_en && (jeff || (q.size() + int'(m_if) < MAXQ));
    pp  = i_en && hv && !i_stall && !jeff;
    if (jeff) begin
      q.delete();
    end else begin
      if (cap) q.push_back('{pc: m_ifpc, inst: mem_word(m_ifpc)});
      if (pp) void'(q.pop_front());
    end
    if (iss) begin
      m_ifpc = eaddr;
      m_pc   = eaddr + 16'd1;
    end
    m_if = iss;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.jump      = 1'b0;
    bus.jump_addr = '0;
    bus.stall     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_addr", 32'(bus.progmem_addr), 32'(RESET_PC));
    rst_n = 1'b1;

    // Free-running stream from reset
    repeat (10) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("stream_cnt_le1", 32'(bus.count <= 3'd1), 32'h1);

    // Stall long enough to fill, then release
    repeat (8) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("stall_full", 32'(bus.count), 32'd4);
    repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Partially fill with a request in flight, then redirect
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0040, 1'b0);
    chk("jump_cnt0", 32'(bus.count), 32'h0);
    repeat (5) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Core disabled with a request in flight; a jump while disabled is ignored
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0123, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Address wrap at the top of the space
    step(1'b1, 1'b1, 16'hFFFE, 1'b0);
    repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r_en, r_jump, r_stall;
      logic [15:0] r_ja;
      r_en    = ($urandom_range(0, 7) != 0);
      r_jump  = ($urandom_range(0, 15) == 0);
      r_stall = ($urandom_range(0, 9) < 3);
      r_ja    = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                            : 16'($urandom);
      step(r_en, r_jump, r_ja, r_stall);
    end

    // Asynchronous reset with the queue full
    repeat (8) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("pre_rst_full", 32'(bus.count), 32'd4);
    bus.en    = 1'b1;
    bus.stall = 1'b1;
    bus.jump  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_count", 32'(bus.count), 32'h0);
    chk("arst_addr", 32'(bus.progmem_addr), 32'(RESET_PC));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0200, 1'b0);
    repeat (4) step(1'b1, 1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
